parking_entry_frontend: RTL and testbench
=========================================

# parking_entry_frontend

Input-conditioning stage that sits directly upstream of the parking-gate controller FSM. It synchronises and debounces the raw entrance/exit vehicle sensors, and assembles two sequential 2-bit keypad strobes into the `password_1`/`password_2` pair the controller compares. It also clears the pair on command, and optionally discards a half-entered pair after a timeout.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced sensor output changes; legal range ≥ 1.
- `ENTRY_TIMEOUT`, default 1000: idle cycles allowed between first and second digit; legal range ≥ 1.

Ports (single clock `clk`; reset is `reset`, synchronous and active-high):
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `sensor_entrance_raw` in 1: asynchronous raw entrance sensor.
- `sensor_exit_raw` in 1: asynchronous raw exit sensor.
- `key_valid` in 1: one-cycle strobe, `key_code` valid.
- `key_code` in 2: keypad digit.
- `key_clear` in 1: abort entry and zero the published pair.
- `sensor_entrance` out 1: debounced entrance sensor, to the controller.
- `sensor_exit` out 1: debounced exit sensor, to the controller.
- `password_1` out 2: first published digit, held.
- `password_2` out 2: second published digit, held.
- `pass_ready` out 1: one-cycle pulse when a new pair is published.
- `entry_timeout` out 1: one-cycle pulse when a pending first digit is discarded.

## Operation
- Sensor path, per sensor:
  - A 2-flop synchroniser feeds the debouncer.
  - The debounce counter counts while the synchronised value ≠ output, and resets to 0 whenever they match.
  - The output toggles, and the counter clears, when the count reaches `DEBOUNCE_CYCLES`.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Entry FSM states and transitions:
  - ENTRY_IDLE: on `key_valid`, capture `key_code` into the pending register and go to GOT_FIRST; the timeout counter is cleared.
  - GOT_FIRST, on `key_valid`: update `password_1` ← pending and `password_2` ← `key_code` in the same cycle, assert `pass_ready`, return to ENTRY_IDLE.
  - GOT_FIRST, no key: the timeout counter increments. When it reaches `ENTRY_TIMEOUT`, discard pending, pulse `entry_timeout`, return to ENTRY_IDLE. Published outputs are unchanged.
- Published pair holds its value until the next complete entry or `key_clear`; a half entry never alters it.
- `key_clear`, any state: go to ENTRY_IDLE, discard pending, set `password_1`/`password_2` to 2'b00, clear the timeout counter. Debouncers are unaffected.
- Priority rules:
  - `key_clear` beats `key_valid` in the same cycle (the key is dropped).
  - `key_valid` beats timeout expiry in the same cycle (the pair is published, no `entry_timeout`).
  - `pass_ready` and `entry_timeout` are never high together.
- `reset`: all outputs 0, FSM in ENTRY_IDLE, all counters 0, synchronisers 0. This applies mid-entry and mid-debounce, and takes effect on the next edge.

## Timing
- Sensor latency: raw edge → debounced output change is 2 + `DEBOUNCE_CYCLES` cycles for a clean edge. A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- Key to publish: a second `key_valid` at cycle N gives `password_1`/`password_2` updated and `pass_ready` high at N+1 (registered outputs).
- Timeout: a first key at cycle N with no further key gives `entry_timeout` at N+1+`ENTRY_TIMEOUT`.
- Back-to-back `key_valid` on consecutive cycles is legal; each is consumed.
- Every output is registered; there is no combinational input-to-output path.

## Configuration
- `PARKING_ENTRY_TIMEOUT_EN` defined: timeout counter and `entry_timeout` behave as above.
- Not defined:
  - No timeout counter is built.
  - GOT_FIRST waits indefinitely; only `key_valid`, `key_clear` or `reset` leave it.
  - `entry_timeout` is tied to 0.
  - `ENTRY_TIMEOUT` is ignored.

## Structure
- Shared package `parking_pkg`:
  - digit width constant (2);
  - entry FSM state typedef (ENTRY_IDLE, GOT_FIRST);
  - password reset/clear value 2'b00.
- The gate controller imports the same digit width constant from `parking_pkg`.
- One sub-module, `sensor_debounce` (synchroniser plus counter, parameterised by `DEBOUNCE_CYCLES`), instantiated twice.

## Test plan
- Reset check: assert `reset` for 2 cycles with all inputs toggling → every output is 0. The first key after release is treated as a first digit.
- Sensor debounce: raw entrance pulses high for 10 cycles (DEBOUNCE_CYCLES=16) → `sensor_entrance` stays 0. Held high for 30 cycles → it rises exactly 18 cycles after the raw edge.
- Pair publish: key 2'b01, then key 2'b10 three cycles later → the next cycle has `password_1`=01, `password_2`=10 and a single `pass_ready` pulse; values hold after.
- Timeout (macro defined, ENTRY_TIMEOUT=8): key 2'b11 at cycle N, no further key → `entry_timeout` pulses at N+9, the published pair is unchanged, and the next key is captured as a first digit.
- Same-cycle priority: `key_clear` with `key_valid` in GOT_FIRST → pair reads 00/00 with no `pass_ready`. `key_valid` on the expiry cycle → pair published with no `entry_timeout`.
- Mid-entry reset: first digit entered, then `reset` → `password_1`/`password_2` are 0 and the FSM is in ENTRY_IDLE. Debounced sensors are 0 even if the raw inputs are high.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: shared digit width, entry FSM states and password clear value for the parking gate blocks
package parking_pkg;
    localparam int DIGIT_W = 2;
    typedef enum logic {ENTRY_IDLE, GOT_FIRST} entry_state_t;
    localparam logic [DIGIT_W-1:0] PASS_CLEAR = '0;
endpackage

// File: rtl/parking_entry_frontend_debounce.sv
// sensor_debounce: 2-flop synchroniser plus stable-count debouncer for one raw sensor
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic debounced
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '0;
            cnt       <= '0;
            debounced <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == debounced) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                debounced <= ~debounced;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/parking_entry_frontend.sv
// parking_entry_frontend: sensor debounce and two-digit keypad pair assembly for the gate controller.
// Define PARKING_ENTRY_TIMEOUT_EN to discard a half-entered pair after ENTRY_TIMEOUT idle cycles.
module parking_entry_frontend
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ENTRY_TIMEOUT   = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensor_entrance_raw,
    input  logic               sensor_exit_raw,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               key_clear,
    output logic               sensor_entrance,
    output logic               sensor_exit,
    output logic [DIGIT_W-1:0] password_1,
    output logic [DIGIT_W-1:0] password_2,
    output logic               pass_ready,
    output logic               entry_timeout
);
    if (DEBOUNCE_CYCLES < 1 || ENTRY_TIMEOUT < 1) begin : g_bad_param
        $error("parking_entry_frontend: DEBOUNCE_CYCLES and ENTRY_TIMEOUT must be >= 1");
    end

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entrance (
        .clk(clk), .reset(reset), .raw(sensor_entrance_raw), .debounced(sensor_entrance)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
        .clk(clk), .reset(reset), .raw(sensor_exit_raw), .debounced(sensor_exit)
    );

    entry_state_t       state, state_d;
    logic [DIGIT_W-1:0] pending, pw1_d, pw2_d;
    logic               publish, capture, expire;

    always_ff @(posedge clk) begin
        if (reset) state <= ENTRY_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = key_clear ? ENTRY_IDLE
                : key_valid ? (state == ENTRY_IDLE ? GOT_FIRST : ENTRY_IDLE)
                : expire    ? ENTRY_IDLE
                :             state;
    end

    // clear outranks a key, and a key outranks expiry
    always_comb begin
        publish = !key_clear && key_valid && state == GOT_FIRST;
        capture = !key_clear && key_valid && state == ENTRY_IDLE;
        pw1_d   = key_clear ? PASS_CLEAR : publish ? pending  : password_1;
        pw2_d   = key_clear ? PASS_CLEAR : publish ? key_code : password_2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            password_1 <= PASS_CLEAR;
            password_2 <= PASS_CLEAR;
            pass_ready <= 1'b0;
        end else begin
            pending    <= capture ? key_code : pending;
            password_1 <= pw1_d;
            password_2 <= pw2_d;
            pass_ready <= publish;
        end
    end

`ifdef PARKING_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(ENTRY_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign expire = state == GOT_FIRST && !key_valid && tcnt == TW'(ENTRY_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt          <= '0;
            entry_timeout <= 1'b0;
        end else begin
            tcnt          <= (key_clear || key_valid || state == ENTRY_IDLE) ? '0 : tcnt + TW'(1);
            entry_timeout <= !key_clear && expire;
        end
    end
`else
    assign expire        = 1'b0;
    assign entry_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_parking_entry_frontend.sv
// tb_parking_entry_frontend: vector table, corner sequences and random run against a spec-level model
module tb_parking_entry_frontend;
    localparam int D = 16;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset, sensor_entrance_raw, sensor_exit_raw, key_valid, key_clear;
    logic [1:0] key_code;
    logic       sensor_entrance, sensor_exit, pass_ready, entry_timeout;
    logic [1:0] password_1, password_2;

    int tests = 0;
    int failed = 0;

    parking_entry_frontend #(.DEBOUNCE_CYCLES(D), .ENTRY_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .sensor_entrance_raw(sensor_entrance_raw), .sensor_exit_raw(sensor_exit_raw),
        .key_valid(key_valid), .key_code(key_code), .key_clear(key_clear),
        .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
        .password_1(password_1), .password_2(password_2),
        .pass_ready(pass_ready), .entry_timeout(entry_timeout)
    );

    always #5 clk = ~clk;

    // reference model: sensor output flips once the last D synchronised samples all disagree with it
    bit         hist[2][D+2];
    bit         m_sens[2];
    bit   [1:0] m_p1, m_p2, first;
    bit         m_rdy, m_to, have;
    int         age;

    task automatic model_step(input bit r, input bit se, input bit sx, input bit kv,
                              input bit [1:0] kc, input bit clr);
        bit raw[2];
        bit all_diff;
        raw[0] = se;
        raw[1] = sx;
        m_rdy = 0;
        m_to  = 0;
        if (r) begin
            for (int s = 0; s < 2; s++) begin
                for (int j = 0; j < D + 2; j++) hist[s][j] = 0;
                m_sens[s] = 0;
            end
            m_p1 = 0; m_p2 = 0; have = 0; age = 0;
            return;
        end
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < D + 1; j++) hist[s][j] = hist[s][j+1];
            hist[s][D+1] = raw[s];
            all_diff = 1;
            for (int j = 0; j < D; j++) if (hist[s][j] == m_sens[s]) all_diff = 0;
            if (all_diff) m_sens[s] = ~m_sens[s];
        end
        if (clr) begin
            m_p1 = 0; m_p2 = 0; have = 0;
        end else if (kv) begin
            if (have) begin
                m_p1 = first; m_p2 = kc; m_rdy = 1; have = 0;
            end else begin
                have = 1; first = kc; age = 0;
            end
        end else if (have) begin
            age++;
`ifdef PARKING_ENTRY_TIMEOUT_EN
            if (age == T) begin
                have = 0; m_to = 1;
            end
`endif
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit se, input bit sx, input bit kv,
                       input bit [1:0] kc, input bit clr);
        reset = r; sensor_entrance_raw = se; sensor_exit_raw = sx;
        key_valid = kv; key_code = kc; key_clear = clr;
        @(posedge clk);
        model_step(r, se, sx, kv, kc, clr);
        #1;
        chk("model", {8'h0, sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_timeout},
            {8'h0, m_sens[0], m_sens[1], m_p1, m_p2, m_rdy, m_to});
    endtask

    typedef struct {
        bit       kv;
        bit [1:0] kc;
        bit       clr;
        bit [1:0] p1, p2;
        bit       rdy;
    } vec_t;
    vec_t tbl[12];

    int  seen, rise, to_at;
    bit  se_r, sx_r;

    initial begin
        tbl[0]  = '{1, 2'b01, 0, 2'b00, 2'b00, 0};
        tbl[1]  = '{0, 2'b11, 0, 2'b00, 2'b00, 0};
        tbl[2]  = '{0, 2'b00, 0, 2'b00, 2'b00, 0};
        tbl[3]  = '{1, 2'b10, 0, 2'b01, 2'b10, 1};
        tbl[4]  = '{0, 2'b01, 0, 2'b01, 2'b10, 0};
        tbl[5]  = '{1, 2'b11, 0, 2'b01, 2'b10, 0};
        tbl[6]  = '{1, 2'b00, 0, 2'b11, 2'b00, 1};
        tbl[7]  = '{1, 2'b10, 0, 2'b11, 2'b00, 0};
        tbl[8]  = '{1, 2'b11, 1, 2'b00, 2'b00, 0};
        tbl[9]  = '{1, 2'b01, 0, 2'b00, 2'b00, 0};
        tbl[10] = '{1, 2'b11, 0, 2'b01, 2'b11, 1};
        tbl[11] = '{0, 2'b00, 0, 2'b01, 2'b11, 0};

        // reset with inputs toggling
        cyc(1, 1, 1, 1, 2'b11, 0);
        cyc(1, 0, 0, 1, 2'b10, 1);
        chk("reset_outs", {10'h0, sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_timeout}, 16'h0);
        cyc(0, 0, 0, 1, 2'b10, 0);
        chk("first_after_reset", {15'h0, pass_ready}, 16'h0);
        cyc(0, 0, 0, 1, 2'b01, 0);
        chk("pair_after_reset", {11'h0, password_1, password_2, pass_ready}, {11'h0, 2'b10, 2'b01, 1'b1});

        cyc(1, 0, 0, 0, 2'b00, 0);
        foreach (tbl[i]) begin
            cyc(0, 0, 0, tbl[i].kv, tbl[i].kc, tbl[i].clr);
            chk($sformatf("vec%0d", i), {11'h0, password_1, password_2, pass_ready},
                {11'h0, tbl[i].p1, tbl[i].p2, tbl[i].rdy});
        end

        // glitch of 10 cycles, then a clean 30-cycle high
        seen = 0;
        for (int i = 0; i < 10; i++) begin cyc(0, 1, 0, 0, 2'b00, 0); seen |= int'(sensor_entrance); end
        for (int i = 0; i < 30; i++) begin cyc(0, 0, 0, 0, 2'b00, 0); seen |= int'(sensor_entrance); end
        chk("glitch_blocked", 16'(seen), 16'h0);
        rise = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc(0, 1, 0, 0, 2'b00, 0);
            if (sensor_entrance && rise == 0) rise = i;
        end
        chk("debounce_latency", 16'(rise), 16'(D + 2));
        for (int i = 0; i < 25; i++) cyc(0, 0, 0, 0, 2'b00, 0);
        chk("debounce_fall", {15'h0, sensor_entrance}, 16'h0);

        // half entry with no second key
        to_at = 0;
        cyc(0, 0, 0, 1, 2'b11, 0);
        for (int i = 2; i <= 14; i++) begin
            cyc(0, 0, 0, 0, 2'b00, 0);
            if (entry_timeout && to_at == 0) to_at = i;
        end
`ifdef PARKING_ENTRY_TIMEOUT_EN
        chk("timeout_cycle", 16'(to_at), 16'(T + 1));
        cyc(0, 0, 0, 1, 2'b10, 0);
        chk("first_after_timeout", {15'h0, pass_ready}, 16'h0);
`else
        chk("no_timeout", 16'(to_at), 16'h0);
        cyc(0, 0, 0, 1, 2'b10, 0);
        chk("pending_kept", {11'h0, password_1, password_2, pass_ready}, {11'h0, 2'b11, 2'b10, 1'b1});
`endif
        chk("pair_kept_on_half", {12'h0, password_1, password_2}, {12'h0, m_p1, m_p2});
        cyc(0, 0, 0, 0, 2'b00, 1);

        // key on the expiry cycle wins
        cyc(0, 0, 0, 1, 2'b01, 0);
        for (int i = 2; i <= T; i++) cyc(0, 0, 0, 0, 2'b00, 0);
        cyc(0, 0, 0, 1, 2'b11, 0);
        chk("key_beats_expiry", {10'h0, password_1, password_2, pass_ready, entry_timeout},
            {10'h0, 2'b01, 2'b11, 1'b1, 1'b0});

        // mid-entry reset with both sensors debounced high
        for (int i = 0; i < D + 4; i++) cyc(0, 1, 1, 0, 2'b00, 0);
        chk("sensors_high", {14'h0, sensor_entrance, sensor_exit}, 16'h3);
        cyc(0, 1, 1, 1, 2'b10, 0);
        cyc(1, 1, 1, 0, 2'b00, 0);
        chk("mid_reset", {10'h0, sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_timeout}, 16'h0);
        cyc(0, 1, 1, 1, 2'b01, 0);
        chk("idle_after_reset", {15'h0, pass_ready}, 16'h0);

        se_r = 0;
        sx_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) se_r = ~se_r;
            if ($urandom_range(0, 11) == 0) sx_r = ~sx_r;
            cyc($urandom_range(0, 199) == 0, se_r, sx_r, $urandom_range(0, 2) == 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
